// File: rtl/imm_rotate_encoder.sv
// imm_rotate_encoder: iterative search for the smallest rot such that the
// 32-bit constant equals an 8-bit immediate rotated right by 2*rot.
// One candidate rotation is tested per clock. The result is reported as
// {rot, imm8} together with an encodable flag.
module imm_rotate_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 8,
    parameter int ROT_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [DATA_WIDTH-1:0]          value,
    output logic                           busy,
    output logic                           done,
    output logic                           valid,
    output logic [ROT_WIDTH+IMM_WIDTH-1:0] shift_operand
);

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t                          state, state_nxt;
    logic [ROT_WIDTH-1:0]            rot_q, rot_nxt;
    logic [DATA_WIDTH-1:0]           cap_q, cap_nxt;
    logic                            done_nxt;
    logic                            valid_nxt;
    logic [ROT_WIDTH+IMM_WIDTH-1:0]  so_nxt;
    logic [DATA_WIDTH-1:0]           cand;
    logic                            fits;
    logic                            last_rot;

    // Rotate left by twice the rot field. A shift by DATA_WIDTH yields zero,
    // so rot=0 degenerates cleanly to the identity.
    function automatic logic [DATA_WIDTH-1:0] rotl2(
        input logic [DATA_WIDTH-1:0] x,
        input logic [ROT_WIDTH-1:0]  r
    );
        logic [ROT_WIDTH:0] sh;
        sh = {r, 1'b0};
        return (x << sh) | (x >> (DATA_WIDTH - int'(sh)));
    endfunction

    // Undoing the right-rotate: the candidate fits when its upper bits are clear.
    always_comb begin
        cand     = rotl2(cap_q, rot_q);
        fits     = ~|cand[DATA_WIDTH-1:IMM_WIDTH];
        last_rot = &rot_q;
    end

    assign busy = (state == SEARCH);

    // Next-state and result logic; results hold unless a search decides.
    always_comb begin
        state_nxt = state;
        rot_nxt   = rot_q;
        cap_nxt   = cap_q;
        done_nxt  = 1'b0;
        valid_nxt = valid;
        so_nxt    = shift_operand;
        case (state)
            IDLE: begin
                if (start) begin
                    cap_nxt   = value;
                    rot_nxt   = '0;
                    state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (fits) begin
                    valid_nxt = 1'b1;
                    so_nxt    = {rot_q, cand[IMM_WIDTH-1:0]};
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (last_rot) begin
                    valid_nxt = 1'b0;
                    so_nxt    = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    rot_nxt = rot_q + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, search registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rot_q         <= '0;
            cap_q         <= '0;
            done          <= 1'b0;
            valid         <= 1'b0;
            shift_operand <= '0;
        end else begin
            state         <= state_nxt;
            rot_q         <= rot_nxt;
            cap_q         <= cap_nxt;
            done          <= done_nxt;
            valid         <= valid_nxt;
            shift_operand <= so_nxt;
        end
    end

endmodule

// File: doc/imm_rotate_encoder.md
Name: imm_rotate_encoder

Overview:
Iterative encoder that converts a 32-bit constant into the data-processing immediate form {rot[3:0], imm8[7:0]}. The encoding satisfies value = imm8 rotated right by 2*rot. It is the inverse of the Val2 immediate-rotate decode path. It is used by the instruction-build and self-test logic to produce 12-bit shift_operand fields. It tests one rotation per clock and reports the smallest legal rot, or reports that the constant is not encodable.

Parameters:
DATA_WIDTH, 32, operand width; the encoding rules assume 32.
IMM_WIDTH, 8, immediate field width.
ROT_WIDTH, 4, rotate field width; candidate rot values run 0 .. 2^ROT_WIDTH-1, and the rotate amount is 2*rot.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request; sampled only while idle.
value  in  32  constant to encode; captured on the accepted start edge.
busy  out  1  high while a search is in progress.
done  out  1  one-cycle pulse; result outputs are valid from this cycle on.
valid  out  1  1 = encodable, 0 = not encodable; held until the next accepted start.
shift_operand  out  12  {rot, imm8}; held until the next accepted start; 0 when valid=0.

Behaviour:
- Reset (rst=1 at a clk edge): state goes to IDLE; busy=0, done=0, valid=0, shift_operand=0, internal rot counter=0 and captured value=0. Reset mid-search aborts the search with no done pulse.
- States:
  - IDLE: busy=0. If start=1, capture value, set rot counter r=0, and go to SEARCH.
  - SEARCH: busy=1. At each edge compute cand = captured value rotated LEFT by 2*r (32-bit rotate, no loss).
    - If cand[31:8]==0: register valid=1 and shift_operand={r[3:0], cand[7:0]}, pulse done next cycle, go to IDLE.
    - Else if r==15: register valid=0 and shift_operand=0, pulse done next cycle, go to IDLE.
    - Else r=r+1 and stay in SEARCH.
- done is a registered pulse: high for exactly one cycle, in the cycle immediately after the deciding SEARCH edge. In that cycle the state is already IDLE and busy=0.
- Latency: start high in cycle 0 -> SEARCH with r=k in cycle k+1 -> done in cycle k+2. k is the winning rot, or 15 on failure. Maximum latency is 17 cycles.
- Result selection: the smallest r wins. value=0 encodes as rot=0, imm8=0.
- start while busy=1 is ignored and has no effect on the running search.
- start in the done cycle is accepted, because the state is IDLE. Outputs keep the old result until the new search decides.
- value changes after capture have no effect.
- Round-trip property: whenever valid=1, {24'b0, imm8} rotated right by 2*rot equals the captured value.

Test Plan:
- rst for 2 cycles, then start with value=0x000000FF -> done in cycle 2, valid=1, shift_operand=0x0FF; busy high in cycle 1 only.
- value=0xF000000F -> rot=2, imm8=0xFF, shift_operand=0x2FF, done in cycle 4.
- value=0xFF000000 -> shift_operand=0x4FF, done in cycle 6; value=0x00000104 -> shift_operand=0xF41, done in cycle 17.
- value=0x00000101 (not encodable) -> done in cycle 17, valid=0, shift_operand=0x000; busy high for cycles 1-16.
- start pulsed repeatedly during a 0x00000104 search -> exactly one done pulse, in cycle 17. A start in the done cycle with value=0 -> second done two cycles later with shift_operand=0x000, valid=1.
- rst asserted in cycle 5 of a 0x00000104 search -> busy=0, valid=0, shift_operand=0 from the next cycle, and no done pulse. Randomised: 1000 random values compared against a model of the minimum-rot rule plus the round-trip property.
